// File: rtl/cpu7_biu_ram.sv
// cpu7_biu_ram: single-outstanding LSU bus responder backed by a word-addressed
// 64-bit RAM with byte-lane writes and fixed read/write handshake latencies.
module cpu7_biu_ram #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned WR_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_biu_rd_req,
  input  logic [31:0] lsu_biu_rd_addr,
  output logic        biu_lsu_rd_ack,
  output logic        biu_lsu_data_valid,
  output logic [63:0] biu_lsu_data,
  input  logic        lsu_biu_wr_req,
  input  logic [31:0] lsu_biu_wr_addr,
  input  logic [63:0] lsu_biu_wr_data,
  input  logic [7:0]  lsu_biu_wr_strb,
  output logic        biu_lsu_wr_ack,
  output logic        biu_lsu_write_done
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = 4;
  localparam int unsigned LANES = 8;
  // Counter preloads: the ack cycle itself accounts for one cycle of latency
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_LAT - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ACK,
    S_RD_WAIT,
    S_WR_ACK,
    S_WR_WAIT
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_idx;
  logic [63:0]   r_wdata;
  logic [7:0]    r_strb;
  logic          r_rd_ack;
  logic          r_data_valid;
  logic [63:0]   r_data;
  logic          r_wr_ack;
  logic          r_write_done;
  logic [63:0]   r_mem [DEPTH];

  logic          w_rd_fire;
  logic          w_wr_commit;
  logic          w_unused_addr_bits;

  // Read data is captured the cycle before data_valid is presented
  assign w_rd_fire = ((r_state == S_RD_ACK) && (RD_LAT == 1)) ||
                     ((r_state == S_RD_WAIT) && !r_data_valid && (r_cnt == CW'(1)));

  // RAM is written in the write_done cycle unless reset aborts the transaction
  assign w_wr_commit = !reset && (r_state == S_WR_WAIT) && r_write_done;

  // Byte offset and out-of-range upper bits only select the wrapped word
  assign w_unused_addr_bits = ^{lsu_biu_rd_addr[31:AW+3], lsu_biu_rd_addr[2:0],
                                lsu_biu_wr_addr[31:AW+3], lsu_biu_wr_addr[2:0]};

  // Handshake FSM with latency counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_rd_ack     <= 1'b0;
      r_data_valid <= 1'b0;
      r_data       <= '0;
      r_wr_ack     <= 1'b0;
      r_write_done <= 1'b0;
    end else begin
      r_rd_ack     <= 1'b0;
      r_wr_ack     <= 1'b0;
      r_data_valid <= 1'b0;
      r_write_done <= 1'b0;
      if (w_rd_fire) begin
        r_data       <= r_mem[r_idx];
        r_data_valid <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (lsu_biu_wr_req) begin
            r_idx    <= lsu_biu_wr_addr[AW+2:3];
            r_wdata  <= lsu_biu_wr_data;
            r_strb   <= lsu_biu_wr_strb;
            r_wr_ack <= 1'b1;
            r_state  <= S_WR_ACK;
          end else if (lsu_biu_rd_req) begin
            r_idx    <= lsu_biu_rd_addr[AW+2:3];
            r_rd_ack <= 1'b1;
            r_state  <= S_RD_ACK;
          end
        end
        S_RD_ACK: begin
          r_cnt   <= RD_LOAD;
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (r_data_valid) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_WR_ACK: begin
          r_cnt <= WR_LOAD;
          if (WR_LAT == 1) begin
            r_write_done <= 1'b1;
          end
          r_state <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (r_write_done) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
              r_write_done <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Byte-lane masked RAM write; unstrobed lanes keep their contents
  always_ff @(posedge clk) begin
    if (w_wr_commit) begin
      for (int b = 0; b < LANES; b++) begin
        if (r_strb[b]) begin
          r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

  assign biu_lsu_rd_ack     = r_rd_ack;
  assign biu_lsu_data_valid = r_data_valid;
  assign biu_lsu_data       = r_data;
  assign biu_lsu_wr_ack     = r_wr_ack;
  assign biu_lsu_write_done = r_write_done;

endmodule

// File: tb/tb_cpu7_biu_ram.sv
// tb_cpu7_biu_ram: three instances (default, RD_LAT=1/WR_LAT=3, RD_LAT=15/WR_LAT=3)
// driven by directed and random transactions against a bench memory model.
module tb_cpu7_biu_ram;

  localparam int unsigned N = 3;

  typedef struct {
    int          k;
    logic [63:0] d;
  } sb_t;

  logic        clk;
  logic        reset;
  logic        rd_req   [N];
  logic [31:0] rd_addr  [N];
  logic        rd_ack   [N];
  logic        valid    [N];
  logic [63:0] data     [N];
  logic        wr_req   [N];
  logic [31:0] wr_addr  [N];
  logic [63:0] wr_data  [N];
  logic [7:0]  wr_strb  [N];
  logic        wr_ack   [N];
  logic        done     [N];

  int          n_checks;
  int          n_errors;
  int          cyc;
  int          n_rdack  [N];
  int          n_wrack  [N];
  int          n_done   [N];
  bit          mon_en;
  int          g_ack_cyc;
  sb_t         sb_q [$];
  logic [63:0] model [N][1024];

  function automatic int rd_lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction

  function automatic int wr_lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[12:3]);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    cpu7_biu_ram #(
      .DEPTH  (1024),
      .RD_LAT ((g == 0) ? 2 : ((g == 1) ? 1 : 15)),
      .WR_LAT ((g == 0) ? 1 : 3)
    ) u_dut (
      .clk                (clk),
      .reset              (reset),
      .lsu_biu_rd_req     (rd_req[g]),
      .lsu_biu_rd_addr    (rd_addr[g]),
      .biu_lsu_rd_ack     (rd_ack[g]),
      .biu_lsu_data_valid (valid[g]),
      .biu_lsu_data       (data[g]),
      .lsu_biu_wr_req     (wr_req[g]),
      .lsu_biu_wr_addr    (wr_addr[g]),
      .lsu_biu_wr_data    (wr_data[g]),
      .lsu_biu_wr_strb    (wr_strb[g]),
      .biu_lsu_wr_ack     (wr_ack[g]),
      .biu_lsu_write_done (done[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Pulse counting and scoreboard check of every data_valid, mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < N; k++) begin
        if (rd_ack[k]) n_rdack[k]++;
        if (wr_ack[k]) n_wrack[k]++;
        if (done[k])   n_done[k]++;
        if (valid[k]) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_valid", 64'(k), 64'hFFFF);
          end else begin
            sb_t e;
            e = sb_q.pop_front();
            chk("rd_dut", 64'(k), 64'(e.k));
            chk("rd_data", data[k], e.d);
          end
        end
      end
    end
  end

  task automatic do_write(input int k, input logic [31:0] a, input logic [63:0] d,
                          input logic [7:0] s);
    int n;
    int m;
    int na;
    na = n_wrack[k];
    wr_addr[k] = a;
    wr_data[k] = d;
    wr_strb[k] = s;
    wr_req[k]  = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!wr_ack[k] && n < 64);
    chk("wr_ack_lat", 64'(n), 64'd1);
    m = 0;
    do begin @(posedge clk); #1; wr_req[k] = 1'b0; m++; end while (!done[k] && m < 64);
    chk("wr_done_lat", 64'(m), 64'(wr_lat_of(k)));
    @(posedge clk); #1;
    chk("wr_ack_count", 64'(n_wrack[k] - na), 64'd1);
    for (int b = 0; b < 8; b++) begin
      if (s[b]) model[k][widx(a)][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic do_read(input int k, input logic [31:0] a, input logic [63:0] exp);
    int n;
    int m;
    int na;
    na = n_rdack[k];
    sb_q.push_back('{k, exp});
    rd_addr[k] = a;
    rd_req[k]  = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!rd_ack[k] && n < 64);
    chk("rd_ack_lat", 64'(n), 64'd1);
    g_ack_cyc = cyc;
    // request stays high through the whole ack cycle
    m = 0;
    do begin @(posedge clk); #1; rd_req[k] = 1'b0; m++; end while (!valid[k] && m < 64);
    chk("rd_valid_lat", 64'(m), 64'(rd_lat_of(k)));
    @(posedge clk); #1;
    chk("rd_ack_count", 64'(n_rdack[k] - na), 64'd1);
  endtask

  initial begin
    int n;
    int m;
    int nd;
    int a1;
    logic [31:0] a;
    logic [63:0] d;
    logic [7:0]  s;

    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    mon_en   = 1'b0;
    reset    = 1'b1;
    for (int k = 0; k < N; k++) begin
      rd_req[k] = 1'b0; rd_addr[k] = '0;
      wr_req[k] = 1'b0; wr_addr[k] = '0; wr_data[k] = '0; wr_strb[k] = '0;
      for (int i = 0; i < 1024; i++) model[k][i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      chk("reset_flags", 64'({rd_ack[k], valid[k], wr_ack[k], done[k]}), 64'd0);
      chk("reset_data", data[k], 64'd0);
    end
    reset  = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Preload word 1, then read it through a high, non-zero-offset alias
    do_write(0, 32'h0000_0008, 64'h1122334455667788, 8'hFF);
    do_read(0, 32'h1c00_0008, 64'h1122334455667788);

    // Partial-strobe write over a zeroed word
    do_write(0, 32'h0000_0010, 64'd0, 8'hFF);
    do_write(0, 32'h0000_0010, 64'hAABBCCDDEEFF0011, 8'h0F);
    do_read(0, 32'h0000_0010, 64'h00000000EEFF0011);

    // Back-to-back reads are accepted four cycles apart
    do_read(0, 32'h0000_0010, 64'h00000000EEFF0011);
    a1 = g_ack_cyc;
    do_read(0, 32'h0000_0008, 64'h1122334455667788);
    chk("b2b_gap", 64'(g_ack_cyc - a1), 64'd4);

    // Simultaneous read and write to the same word: write wins
    sb_q.push_back('{0, 64'h0123456789ABCDEF});
    nd = n_done[0];
    wr_addr[0] = 32'h0000_0100; wr_data[0] = 64'h0123456789ABCDEF; wr_strb[0] = 8'hFF;
    rd_addr[0] = 32'h0000_0100;
    wr_req[0]  = 1'b1;
    rd_req[0]  = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!wr_ack[0] && n < 64);
    chk("sim_wr_ack_lat", 64'(n), 64'd1);
    chk("sim_rd_ack_early", 64'(rd_ack[0]), 64'd0);
    do begin @(posedge clk); #1; wr_req[0] = 1'b0; n++; end while (!rd_ack[0] && n < 64);
    chk("sim_rd_ack_lat", 64'(n), 64'd4);
    chk("sim_done_before_rd", 64'(n_done[0] - nd), 64'd1);
    m = 0;
    do begin @(posedge clk); #1; rd_req[0] = 1'b0; m++; end while (!valid[0] && m < 64);
    chk("sim_valid_lat", 64'(m), 64'd2);
    model[0][widx(32'h100)] = 64'h0123456789ABCDEF;
    @(posedge clk); #1;

    // Address wrap at DEPTH*8 bytes; low address bits ignored
    do_write(0, 32'h0000_2008, 64'hCAFEF00DDEADBEEF, 8'hFF);
    do_read(0, 32'h0000_0008, 64'hCAFEF00DDEADBEEF);
    do_read(0, 32'h0000_000D, 64'hCAFEF00DDEADBEEF);

    // Reset in the cycle after wr_ack abandons the write
    do_write(0, 32'h0000_0040, 64'h5555AAAA5555AAAA, 8'hFF);
    nd = n_done[0];
    wr_addr[0] = 32'h0000_0040; wr_data[0] = 64'hDEADDEADDEADDEAD; wr_strb[0] = 8'hFF;
    wr_req[0]  = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!wr_ack[0] && n < 64);
    chk("rst_wr_ack_lat", 64'(n), 64'd1);
    reset     = 1'b1;
    wr_req[0] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_done_low", 64'(done[0]), 64'd0);
    end
    chk("rst_flags", 64'({rd_ack[0], valid[0], wr_ack[0], done[0]}), 64'd0);
    chk("rst_data", data[0], 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    do_read(0, 32'h0000_0040, 64'h5555AAAA5555AAAA);
    chk("rst_no_done", 64'(n_done[0] - nd), 64'd0);

    // Latency sweep instances, including an all-zero strobe write
    for (int k = 1; k < N; k++) begin
      d = {$urandom, $urandom};
      do_write(k, 32'h0000_0030, d, 8'hFF);
      do_read(k, 32'h0000_0030, model[k][widx(32'h30)]);
      do_write(k, 32'h0000_0030, ~d, 8'h00);
      do_read(k, 32'h0000_0030, d);
    end

    // Random mixed traffic on a small window of words
    for (int i = 0; i < 8; i++) begin
      do_write(0, 32'((32 + i) * 8), {$urandom, $urandom}, 8'hFF);
    end
    for (int i = 0; i < 16; i++) begin
      a = 32'((32 + $urandom_range(0, 7)) * 8 + $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        d = {$urandom, $urandom};
        s = 8'($urandom);
        do_write(0, a, d, s);
      end else begin
        do_read(0, a, model[0][widx(a)]);
      end
    end

    repeat (4) @(posedge clk);
    #1;
    chk("sb_left", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu7_biu_ram.md
# cpu7_biu_ram

Bus-side responder for the core's LSU memory interface. It accepts single-beat 64-bit read and write requests from the LSU, stores data in an internal word-addressed RAM, and answers with the ack, data-valid and write-done handshakes the LSU expects. It sits directly outside `cpu7_core`, so simulation and FPGA builds can run load/store code without an external bus or BIU.

## Interface
Parameters:
- `DEPTH`, 1024: number of 64-bit words; power of two, ≥ 2.
- `RD_LAT`, 2: cycles from `biu_lsu_rd_ack` to `biu_lsu_data_valid`; 1..15.
- `WR_LAT`, 1: cycles from `biu_lsu_wr_ack` to `biu_lsu_write_done`; 1..15.

Ports:
- `clk` in 1: the only clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `lsu_biu_rd_req` in 1: read request, held by the LSU until it sees ack.
- `lsu_biu_rd_addr` in 32: byte address of the read.
- `biu_lsu_rd_ack` out 1: one-cycle pulse; read accepted.
- `biu_lsu_data_valid` out 1: one-cycle pulse; `biu_lsu_data` is valid.
- `biu_lsu_data` out 64: read data.
- `lsu_biu_wr_req` in 1: write request, held until ack.
- `lsu_biu_wr_addr` in 32: byte address of the write.
- `lsu_biu_wr_data` in 64: write data, aligned to the 64-bit word.
- `lsu_biu_wr_strb` in 8: byte enables; bit i enables byte lane i (bits 8i+7:8i).
- `biu_lsu_wr_ack` out 1: one-cycle pulse; write accepted.
- `biu_lsu_write_done` out 1: one-cycle pulse; write committed.

## Operation
- Word index = `addr[log2(DEPTH)+2:3]`. Address bits [2:0] and all bits above the index are ignored, so addresses wrap modulo DEPTH×8.
- Only one transaction is outstanding at a time. There are no queues.
- FSM states: IDLE, RD_ACK, RD_WAIT, WR_ACK, WR_WAIT.
- In IDLE, requests are sampled every cycle:
  - If `lsu_biu_wr_req` is high, capture address, data and strobes, then go to WR_ACK. Write has priority when both requests are high; the read stays pending and is sampled later.
  - Otherwise, if `lsu_biu_rd_req` is high, capture the address, then go to RD_ACK.
- RD_ACK: drive `rd_ack` = 1, load the latency counter with RD_LAT, go to RD_WAIT.
- RD_WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, RAM read data is registered onto `biu_lsu_data`.
  - In the following cycle, `data_valid` = 1 and the FSM returns to IDLE.
- WR_ACK: drive `wr_ack` = 1, load the counter with WR_LAT, go to WR_WAIT.
- WR_WAIT:
  - When the counter expires, write the RAM: only lanes with strobe = 1 are written; other lanes keep their old value.
  - `write_done` = 1 in the same cycle, then return to IDLE.
- An all-zero strobe still completes the full handshake and leaves the RAM unchanged.
- Requests are ignored in any state other than IDLE. The LSU holding `req` high through the ack cycle must not cause a second acceptance.
- Reset:
  - FSM goes to IDLE, the counter clears, and every output is 0, including `biu_lsu_data`.
  - RAM contents are not cleared.
  - A transaction in flight when reset asserts is abandoned: no ack, valid or done pulse is produced after reset, and an interrupted write does not modify the RAM.
- `biu_lsu_data` holds the last read value between reads.

## Timing
- A request is sampled in IDLE at cycle T. The ack pulse is at T+1.
- Read: `data_valid` at T+1+RD_LAT.
- Write: `write_done` at T+1+WR_LAT. The RAM holds the new value from T+2+WR_LAT.
- The FSM is in IDLE again at the cycle after `data_valid` or `write_done`. That is the earliest a new request can be sampled.
- Back-to-back read with RD_LAT=2: accepted requests are 4 cycles apart.
- Read-after-write to the same address, with the read sampled after `write_done`, returns the new data.
- Simultaneous rd+wr in IDLE at T:
  - `wr_ack` at T+1.
  - The read is sampled at T+2+WR_LAT.
  - `rd_ack` at T+3+WR_LAT.

## Test plan
- Reset, then read address 0x1c000008 with RD_LAT=2 and word 1 preloaded with 0x1122334455667788:
  - req at T, `rd_ack` at T+1, `data_valid` at T+3, data = 0x1122334455667788.
  - No second ack even though req stays high through T+1.
- Write 0xAABBCCDDEEFF0011 to address 0x10 with strb 0x0F over an old word of 0:
  - `wr_ack` at T+1, `write_done` at T+2.
  - A following read returns 0x00000000EEFF0011.
- rd_req and wr_req asserted in the same IDLE cycle to the same address:
  - `wr_ack` comes first.
  - The read is acked only after `write_done` and returns the written data.
- Wrap-around with DEPTH=1024: write address 0x2008, then read address 0x0008; the same word is returned. Low bits 0x5 in the address do not change the word selected.
- Assert `reset` in the cycle after `wr_ack`:
  - No `write_done` pulse is produced.
  - The RAM word is unchanged and all outputs are 0.
  - A new read after reset completes normally.
- Sweep RD_LAT=1 and RD_LAT=15 with WR_LAT=3: measured ack-to-valid and ack-to-done distances equal the parameters exactly.
